// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// Memory handshake: the controller holds mem_req high for the whole access;
// the access completes in the cycle where mem_req && mem_ready, and only then
// does the controller move on (mem_req acts as valid, mem_ready as ready).
interface mc_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       irwrite;
    logic       alu_src_a;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alucontrol;
    logic       pc_en;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, iord, irwrite, alu_src_a, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_b, pc_src, alucontrol, pc_en,
               instr_done, illegal
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, iord, irwrite, alu_src_a, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_b, pc_src, alucontrol, pc_en,
               instr_done, illegal
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset controller: Moore FSM sequencing fetch, decode and
// per-instruction execute/writeback steps over a unified memory.
module mc_controller #(
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic              clk,
    input  logic              rst,
    mc_controller_if.master   bus,
    output logic [3:0]        state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;
    logic   ready;

    // With the handshake disabled every access completes in one cycle.
    assign ready     = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
    assign state_dbg = state_q;

    // State register; reset wins over any pending transition.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode from state; enables are forced low while in reset.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.iord       = 1'b0;
        bus.irwrite    = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.pc_src     = 2'b00;
        bus.alucontrol = ALU_ADD;
        bus.pc_en      = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.irwrite   = ready;
                bus.pc_en     = ready;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J: bus.illegal = 1'b0;
                    default:                                   bus.illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_req    = 1'b1;
                bus.iord       = 1'b1;
                bus.mem_write  = ready;
                bus.instr_done = ready;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                case (bus.funct)
                    6'b100000: bus.alucontrol = ALU_ADD;
                    6'b100010: bus.alucontrol = ALU_SUB;
                    6'b100100: bus.alucontrol = ALU_AND;
                    6'b100101: bus.alucontrol = ALU_OR;
                    6'b101010: bus.alucontrol = ALU_SLT;
                    default: begin
                        bus.alucontrol = ALU_ADD;
                        bus.illegal    = 1'b1;
                    end
                endcase
            end
            S_ALUWB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alucontrol = ALU_SUB;
                bus.pc_src     = 2'b01;
                bus.pc_en      = bus.zero;
                bus.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_JUMP: begin
                bus.pc_src     = 2'b10;
                bus.pc_en      = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: begin
                bus.mem_req = 1'b0;
            end
        endcase
        if (rst) begin
            bus.mem_req    = 1'b0;
            bus.irwrite    = 1'b0;
            bus.mem_write  = 1'b0;
            bus.reg_write  = 1'b0;
            bus.pc_en      = 1'b0;
            bus.instr_done = 1'b0;
            bus.illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each cycle drives inputs, queues the
// expected state/output vector and compares it mid-cycle.
module tb_mc_controller;

    localparam int W = 22;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic [3:0] state_dbg;
    always #5 clk = ~clk;

    mc_controller_if bus();

    mc_controller #(.MEM_HANDSHAKE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    logic [W-1:0] obs;
    assign obs = {state_dbg, bus.mem_req, bus.iord, bus.irwrite, bus.alu_src_a,
                  bus.mem_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                  bus.alu_src_b, bus.pc_src, bus.alucontrol,
                  bus.pc_en, bus.instr_done, bus.illegal};

    // ---------------- expected vectors ----------------
    function automatic logic [W-1:0] mk(
        input logic [3:0] st, input logic req, input logic iord, input logic irw,
        input logic asa, input logic mw, input logic m2r, input logic rd,
        input logic rw, input logic [1:0] asb, input logic [1:0] pcs,
        input logic [2:0] aluc, input logic pce, input logic done, input logic ill);
        return {st, req, iord, irw, asa, mw, m2r, rd, rw, asb, pcs, aluc, pce, done, ill};
    endfunction

    function automatic logic [W-1:0] e_fetch(input logic r);
        return mk(S_FETCH, 1, 0, r, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, r, 0, 0);
    endfunction
    function automatic logic [W-1:0] e_decode(input logic ill);
        return mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0, 0, ill);
    endfunction
    function automatic logic [W-1:0] e_memadr();
        return mk(S_MEMADR, 0, 0, 0, 1, 0, 0, 0, 0, 2'b10, 2'b00, 3'b010, 0, 0, 0);
    endfunction
    function automatic logic [W-1:0] e_memrd();
        return mk(S_MEMRD, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0, 0, 0);
    endfunction
    function automatic logic [W-1:0] e_memwb();
        return mk(S_MEMWB, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 3'b010, 0, 1, 0);
    endfunction
    function automatic logic [W-1:0] e_memwr(input logic r);
        return mk(S_MEMWR, 1, 1, 0, 0, r, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0, r, 0);
    endfunction
    function automatic logic [W-1:0] e_exec(input logic [2:0] ac, input logic ill);
        return mk(S_EXEC, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, ac, 0, 0, ill);
    endfunction
    function automatic logic [W-1:0] e_aluwb();
        return mk(S_ALUWB, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 3'b010, 0, 1, 0);
    endfunction
    function automatic logic [W-1:0] e_branch(input logic z);
        return mk(S_BRANCH, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 3'b110, z, 1, 0);
    endfunction
    function automatic logic [W-1:0] e_addiex();
        return mk(S_ADDIEX, 0, 0, 0, 1, 0, 0, 0, 0, 2'b10, 2'b00, 3'b010, 0, 0, 0);
    endfunction
    function automatic logic [W-1:0] e_addiwb();
        return mk(S_ADDIWB, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0, 1, 0);
    endfunction
    function automatic logic [W-1:0] e_jump();
        return mk(S_JUMP, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 1, 1, 0);
    endfunction

    logic [W-1:0] full_mask;
    logic [W-1:0] rst_mask;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           errors = 0;

    // One clock cycle: drive inputs just after the edge, queue the expectation,
    // then compare mid-cycle once outputs have settled.
    task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [W-1:0] e,
                       input logic [W-1:0] m, input string tag);
        logic [W-1:0] ee;
        logic [W-1:0] mm;
        string        tt;
        rst           = r;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        msk_q.push_back(m);
        tag_q.push_back(tag);
        #4;
        ee = exp_q.pop_front();
        mm = msk_q.pop_front();
        tt = tag_q.pop_front();
        checks++;
        assert ((obs & mm) === (ee & mm)) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h mask=%h", tt, obs, ee, mm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rdy, input logic [W-1:0] e, input string tag);
        cyc(1'b0, op, fn, z, rdy, e, full_mask, tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        full_mask = '1;
        rst_mask  = mk(4'h0, 1, 0, 1, 0, 1, 0, 0, 1, 2'b00, 2'b00, 3'b000, 1, 1, 1);
        rst = 1'b1;
        bus.opcode = OP_BAD; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk); #1;

        // reset: enables low even with FETCH state and mem_ready high
        cyc(1, OP_LW, 6'd0, 0, 1, '0, rst_mask, "reset0");
        cyc(1, OP_LW, 6'd0, 0, 1, '0, rst_mask, "reset1");

        // lw, no wait states: 5 cycles
        run(OP_LW, 6'd0, 0, 1, e_fetch(1), "lw_fetch");
        run(OP_LW, 6'd0, 0, 1, e_decode(0), "lw_decode");
        run(OP_LW, 6'd0, 0, 1, e_memadr(), "lw_memadr");
        run(OP_LW, 6'd0, 0, 1, e_memrd(), "lw_memrd");
        run(OP_LW, 6'd0, 0, 1, e_memwb(), "lw_memwb");

        // R slt: 4 cycles
        run(OP_R, 6'b101010, 0, 1, e_fetch(1), "slt_fetch");
        run(OP_R, 6'b101010, 0, 1, e_decode(0), "slt_decode");
        run(OP_R, 6'b101010, 0, 1, e_exec(3'b111, 0), "slt_exec");
        run(OP_R, 6'b101010, 0, 1, e_aluwb(), "slt_aluwb");

        // other R functs, including an unknown one
        run(OP_R, 6'b100010, 0, 1, e_fetch(1), "sub_fetch");
        run(OP_R, 6'b100010, 0, 1, e_decode(0), "sub_decode");
        run(OP_R, 6'b100010, 0, 1, e_exec(3'b110, 0), "sub_exec");
        run(OP_R, 6'b100010, 0, 1, e_aluwb(), "sub_aluwb");
        run(OP_R, 6'b100101, 0, 1, e_fetch(1), "or_fetch");
        run(OP_R, 6'b100101, 0, 1, e_decode(0), "or_decode");
        run(OP_R, 6'b100101, 0, 1, e_exec(3'b001, 0), "or_exec");
        run(OP_R, 6'b100101, 0, 1, e_aluwb(), "or_aluwb");
        run(OP_R, 6'b000111, 0, 1, e_fetch(1), "badfn_fetch");
        run(OP_R, 6'b000111, 0, 1, e_decode(0), "badfn_decode");
        run(OP_R, 6'b000111, 0, 1, e_exec(3'b010, 1), "badfn_exec");
        run(OP_R, 6'b000111, 0, 1, e_aluwb(), "badfn_aluwb");

        // beq taken then not taken: 3 cycles each
        run(OP_BEQ, 6'd0, 1, 1, e_fetch(1), "beq1_fetch");
        run(OP_BEQ, 6'd0, 1, 1, e_decode(0), "beq1_decode");
        run(OP_BEQ, 6'd0, 1, 1, e_branch(1), "beq1_branch");
        run(OP_BEQ, 6'd0, 0, 1, e_fetch(1), "beq0_fetch");
        run(OP_BEQ, 6'd0, 0, 1, e_decode(0), "beq0_decode");
        run(OP_BEQ, 6'd0, 0, 1, e_branch(0), "beq0_branch");

        // sw with three wait states: 7 cycles
        run(OP_SW, 6'd0, 0, 1, e_fetch(1), "sw_fetch");
        run(OP_SW, 6'd0, 0, 1, e_decode(0), "sw_decode");
        run(OP_SW, 6'd0, 0, 1, e_memadr(), "sw_memadr");
        run(OP_SW, 6'd0, 0, 0, e_memwr(0), "sw_wait1");
        run(OP_SW, 6'd0, 0, 0, e_memwr(0), "sw_wait2");
        run(OP_SW, 6'd0, 0, 0, e_memwr(0), "sw_wait3");
        run(OP_SW, 6'd0, 0, 1, e_memwr(1), "sw_write");

        // illegal opcode
        run(OP_BAD, 6'd0, 0, 1, e_fetch(1), "ill_fetch");
        run(OP_BAD, 6'd0, 0, 1, e_decode(1), "ill_decode");

        // addi (also shows illegal returned to FETCH)
        run(OP_ADDI, 6'd0, 0, 1, e_fetch(1), "addi_fetch");
        run(OP_ADDI, 6'd0, 0, 1, e_decode(0), "addi_decode");
        run(OP_ADDI, 6'd0, 0, 1, e_addiex(), "addi_ex");
        run(OP_ADDI, 6'd0, 0, 1, e_addiwb(), "addi_wb");

        // jump, with two fetch wait states first
        run(OP_J, 6'd0, 0, 0, e_fetch(0), "j_fetchwait1");
        run(OP_J, 6'd0, 0, 0, e_fetch(0), "j_fetchwait2");
        run(OP_J, 6'd0, 0, 1, e_fetch(1), "j_fetch");
        run(OP_J, 6'd0, 0, 1, e_decode(0), "j_decode");
        run(OP_J, 6'd0, 0, 1, e_jump(), "j_jump");

        // reset while waiting in MEMRD: no MEMWB, back to FETCH
        run(OP_LW, 6'd0, 0, 1, e_fetch(1), "rlw_fetch");
        run(OP_LW, 6'd0, 0, 1, e_decode(0), "rlw_decode");
        run(OP_LW, 6'd0, 0, 1, e_memadr(), "rlw_memadr");
        run(OP_LW, 6'd0, 0, 0, e_memrd(), "rlw_memrd_wait");
        cyc(1, OP_LW, 6'd0, 0, 1, '0, rst_mask, "rlw_reset");
        run(OP_LW, 6'd0, 0, 1, e_fetch(1), "rlw_after_reset");
        run(OP_LW, 6'd0, 0, 1, e_decode(0), "rlw2_decode");
        run(OP_LW, 6'd0, 0, 1, e_memadr(), "rlw2_memadr");
        run(OP_LW, 6'd0, 0, 1, e_memrd(), "rlw2_memrd");
        run(OP_LW, 6'd0, 0, 1, e_memwb(), "rlw2_memwb");

        // lw with random wait states in MEMRD
        for (int k = 0; k < 4; k++) begin
            int w;
            w = $urandom_range(0, 3);
            run(OP_LW, 6'd0, 0, 1, e_fetch(1), "rnd_fetch");
            run(OP_LW, 6'd0, 0, 1, e_decode(0), "rnd_decode");
            run(OP_LW, 6'd0, 0, 1, e_memadr(), "rnd_memadr");
            for (int j = 0; j < w; j++)
                run(OP_LW, 6'd0, 0, 0, e_memrd(), "rnd_memrd_wait");
            run(OP_LW, 6'd0, 0, 1, e_memrd(), "rnd_memrd");
            run(OP_LW, 6'd0, 0, 1, e_memwb(), "rnd_memwb");
        end

        // back to FETCH after the last writeback
        run(OP_LW, 6'd0, 0, 0, e_fetch(0), "final_fetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have parameter MEM_HANDSHAKE, default 1; 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored and treated as 1.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port opcode, input, 6, instr[31:26] from the instruction register.
REQ-005 The block SHALL have port funct, input, 6, instr[5:0] from the instruction register.
REQ-006 The block SHALL have port zero, input, 1, ALU zero flag.
REQ-007 The block SHALL have port mem_ready, input, 1, unified memory completes the current access this cycle.
REQ-008 The block SHALL have port mem_req, output, 1, memory access request.
REQ-009 The block SHALL have ports iord, irwrite, alu_src_a, mem_write, mem_to_reg, reg_dst, reg_write, outputs, 1 each, datapath mux/enable controls.
REQ-010 The block SHALL have ports alu_src_b and pc_src, outputs, 2 each (alu_src_b: 00 reg B, 01 const 4, 10 imm_ext, 11 imm_ext<<2; pc_src: 00 ALU out, 01 ALUOut reg, 10 jump target).
REQ-011 The block SHALL have port alucontrol, output, 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-012 The block SHALL have port pc_en, output, 1, PC register load enable.
REQ-013 The block SHALL have ports instr_done and illegal, outputs, 1 each, single-cycle pulses.

Function
REQ-014 The block SHALL be a Moore FSM with registered state; all outputs decode combinationally from state, except alucontrol in EXEC (from funct), pc_en in BRANCH (from zero), and mem-gated enables (REQ-017).
REQ-015 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-016 Opcodes SHALL be: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-017 FETCH SHALL drive mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alucontrol=010, pc_src=00, and SHALL assert irwrite and pc_en, and advance to DECODE, only in the cycle mem_ready=1; otherwise hold FETCH with irwrite=pc_en=0.
REQ-018 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alucontrol=010, then go to MEMADR (lw/sw), EXEC (R), BRANCH (beq), ADDIEX (addi), JUMP (j); any other opcode -> FETCH with illegal=1 for that cycle.
REQ-019 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alucontrol=010, then go to MEMRD (lw) or MEMWR (sw).
REQ-020 MEMRD SHALL drive mem_req=1, iord=1; go to MEMWB when mem_ready=1, else hold.
REQ-021 MEMWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1; -> FETCH.
REQ-022 MEMWR SHALL drive mem_req=1, iord=1, with mem_write=1 only while mem_ready=1; on mem_ready=1 assert instr_done and go to FETCH, else hold.
REQ-023 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alucontrol from funct (100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010 with illegal=1); -> ALUWB.
REQ-024 ALUWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; -> FETCH.
REQ-025 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alucontrol=110, pc_src=01, pc_en=zero, instr_done=1; -> FETCH.
REQ-026 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alucontrol=010; -> ADDIWB, which drives reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; -> FETCH.
REQ-027 JUMP SHALL drive pc_src=10, pc_en=1, instr_done=1; -> FETCH.
REQ-028 Any output not listed for a state SHALL be 0 (alucontrol 010, alu_src_b/pc_src 00).
REQ-029 Unreachable state encodings SHALL return to FETCH next cycle with all enables 0.
REQ-030 CPI SHALL be: lw 5, sw 4, R 4, addi 4, beq 3, j 3 with zero wait states; each mem_ready=0 cycle adds one.

Reset
REQ-031 rst=1 at a clock edge SHALL force state FETCH regardless of current state, including mid-wait in MEMRD/MEMWR; rst has priority over all transitions.
REQ-032 While rst=1, pc_en, irwrite, reg_write, mem_write, mem_req, instr_done, illegal SHALL be 0.
REQ-033 The first cycle after rst deasserts SHALL be FETCH with mem_req=1.

Verification
REQ-034 Reset then opcode=100011, mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1, mem_to_reg=1 in cycle 5; instr_done once.
REQ-035 opcode=000000, funct=101010 -> EXEC alucontrol=111, ALUWB reg_dst=1, reg_write=1; 4 cycles.
REQ-036 opcode=000100 with zero=1 then zero=0 -> pc_en=1 then pc_en=0 in BRANCH, pc_src=01, alucontrol=110.
REQ-037 sw with mem_ready low 3 cycles in MEMWR -> mem_write=0 for those 3 cycles, 1 only on ready cycle; total 7 cycles.
REQ-038 opcode=111111 -> illegal=1 in DECODE, next state FETCH, no reg_write/mem_write/pc_en.
REQ-039 rst=1 during MEMRD wait -> next state FETCH, no MEMWB, no reg_write.
